instruction_fetch_unit: RTL

- Holds the program counter (PC), memory address register (MAR) and instruction register (IR) for the SAP-1+ datapath.
- Sits directly upstream of the controller: it feeds the controller's 16-bit instruction input and executes the PC/MAR/IR control strobes the controller issues each cycle.
- Drives the shared bus with the PC value or the IR operand, drives the RAM address, and keeps debug status (halted, bus conflict, instruction count).

---
 rtl/sap_pkg.sv | 32 +++
 rtl/program_counter.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared SAP-1+ opcodes, field positions and fetch-unit state type
package sap_pkg;

    localparam int SAP_DATA_WIDTH = 16;
    localparam int OPCODE_WIDTH   = 8;
    localparam int OPCODE_LSB     = SAP_DATA_WIDTH - OPCODE_WIDTH;
    localparam int OPERAND_LSB    = 0;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP = 8'd0,
        OP_LDA = 8'd1,
        OP_ADD = 8'd2,
        OP_SUB = 8'd3,
        OP_STA = 8'd4,
        OP_LDI = 8'd5,
        OP_JMP = 8'd6,
        OP_JC  = 8'd7,
        OP_JZ  = 8'd8,
        OP_OUT = 8'd14,
        OP_HLT = 8'd15
    } opcode_t;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_t;

    function automatic opcode_t opcode_of(input logic [SAP_DATA_WIDTH-1:0] instruction);
        return opcode_t'(instruction[OPCODE_LSB +: OPCODE_WIDTH]);
    endfunction

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter with jump-over-increment priority and freeze
module program_counter #(
    parameter int ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_freeze,
    input  logic                  i_jump,
    input  logic                  i_increment,
    input  logic [ADDR_WIDTH-1:0] i_jump_address,
    output logic [ADDR_WIDTH-1:0] o_count
);

    // Increment wraps naturally at 2^ADDR_WIDTH.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_count <= RESET_VECTOR;
        end else if (!i_freeze) begin
            if (i_jump) begin
                o_count <= i_jump_address;
            end else if (i_increment) begin
                o_count <= o_count + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, MAR and IR with bus drive and debug status for SAP-1+
module instruction_fetch_unit
    import sap_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = SAP_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_debug,
    input  logic                  i_halt,
    input  logic                  i_memory_address_in,
    input  logic                  i_program_counter_increment,
    input  logic                  i_program_counter_out,
    input  logic                  i_program_counter_jump,
    input  logic                  i_instruction_in,
    input  logic                  i_instruction_out,
    input  logic [DATA_WIDTH-1:0] i_bus,
    output logic [DATA_WIDTH-1:0] o_instruction,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0] o_bus_data,
    output logic                  o_bus_drive,
    output logic                  o_halted,
    output logic                  o_bus_conflict,
    output logic [15:0]           o_instruction_count
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] mar_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic                  conflict_q;
    logic [15:0]           count_q;
    logic                  freeze;
    logic                  unused_debug;

    assign unused_debug = i_debug;
    assign freeze       = i_halt || (state_q == FETCH_HALTED);

    program_counter #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_program_counter (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_freeze       (freeze),
        .i_jump         (i_program_counter_jump),
        .i_increment    (i_program_counter_increment),
        .i_jump_address (i_bus[ADDR_WIDTH-1:0]),
        .o_count        (pc)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= FETCH_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Halted is terminal until reset.
    always_comb begin
        state_d = state_q;
        if (i_halt) begin
            state_d = FETCH_HALTED;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            mar_q      <= '0;
            ir_q       <= '0;
            count_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (i_program_counter_out && i_instruction_out) begin
                conflict_q <= 1'b1;
            end
            if (!freeze) begin
                if (i_memory_address_in) begin
                    mar_q <= i_bus[ADDR_WIDTH-1:0];
                end
                if (i_instruction_in) begin
                    ir_q <= i_bus;
                    if (count_q != 16'hFFFF) begin
                        count_q <= count_q + 16'd1;
                    end
                end
            end
        end
    end

    // PC has priority when both drivers are requested.
    always_comb begin
        o_bus_data = '0;
        if (i_program_counter_out) begin
            o_bus_data = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, pc};
        end else if (i_instruction_out) begin
            o_bus_data = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, ir_q[OPERAND_LSB +: ADDR_WIDTH]};
        end
    end

    assign o_bus_drive         = i_program_counter_out | i_instruction_out;
    assign o_instruction       = ir_q;
    assign o_address           = mar_q;
    assign o_halted            = (state_q == FETCH_HALTED);
    assign o_bus_conflict      = conflict_q;
    assign o_instruction_count = count_q;

endmodule
